shifter_operand_seq: RTL and testbench
======================================

SHIFTER_OPERAND_SEQ -- requirements
Module: shifter_operand_seq

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port instr_valid  in  1  data-processing instruction offered.
REQ-004 SHALL have port instr  in  32  instruction word: [25]=I, [11:8]=rot/Rs, [7:0]=imm8, [11:7]=shift_imm, [6:5]=shift, [4]=regshift, [3:0]=Rm.
REQ-005 SHALL have port instr_ready  out  1  high only in IDLE.
REQ-006 SHALL have port rf_addr  out  4  register-file read address; async-read RF, data valid same cycle.
REQ-007 SHALL have port rf_rd_en  out  1  high in RD_RS and RD_RM.
REQ-008 SHALL have port rf_data  in  32  register-file read data.
REQ-009 SHALL have port cflag  in  1  CPSR C flag.
REQ-010 SHALL have port op_valid  out  1  operands for shifter_32 valid.
REQ-011 SHALL have port op_ready  in  1  downstream accepts operands.
REQ-012 SHALL have ports Rm (out, 32), shift_imm (out, 5), shift (out, 2), carry_in (out, 1), shift_en (out, 1) driving shifter_32; shift_en equals op_valid.
REQ-013 SHALL have ports bypass_en (out, 1), bypass_val (out, 32), bypass_c (out, 1): result override for register shift amounts >= 32.
REQ-014 SHALL have port illegal  out  1  unsupported form flagged (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RD_RS, RD_RM, OUT.
REQ-016 SHALL accept when instr_valid && instr_ready at a rising edge, capturing instr and cflag; carry_in holds the cflag captured at accept.
REQ-017 Immediate form (I=1): IDLE->OUT; Rm={24'b0,imm8}; rot!=0 -> shift=11, shift_imm={rot,1'b0}; rot==0 -> shift=00, shift_imm=0; op_valid high 1 cycle after accept; no RF read.
REQ-018 Immediate shift (I=0, [4]=0): IDLE->RD_RM->OUT; rf_addr=instr[3:0] in RD_RM, rf_data captured into Rm at its end; shift, shift_imm passed through from instr; op_valid 2 cycles after accept.
REQ-019 Register shift (I=0, [4]=1): IDLE->RD_RS->RD_RM->OUT; rf_addr=instr[11:8] in RD_RS, amt=rf_data[7:0] captured; then Rm read as REQ-018; op_valid 3 cycles after accept.
REQ-020 Register shift amount mapping: amt==0 -> shift=00, shift_imm=0, bypass_en=0; amt 1..31 -> shift=instr[6:5], shift_imm=amt[4:0], bypass_en=0.
REQ-021 amt>=32, bypass_en=1: LSL amt==32 -> val 0, c=Rm[0]; LSL >32 -> 0,0; LSR amt==32 -> 0, c=Rm[31]; LSR >32 -> 0,0; ASR -> val all Rm[31], c=Rm[31]; ROR amt[4:0]==0 -> val Rm, c=Rm[31]; ROR amt[4:0]!=0 -> bypass_en=0, shift=11, shift_imm=amt[4:0].
REQ-022 In OUT, all operand/bypass outputs SHALL hold stable until op_ready=1; on op_valid && op_ready -> IDLE next edge, op_valid low.
REQ-023 No new accept while not in IDLE; instr ignored outside IDLE.
REQ-024 instr_ready, rf_addr, rf_rd_en SHALL be decoded from state; all other outputs registered; rf_addr=0 when rf_rd_en=0.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, op_valid=0, bypass_en=0, illegal=0, Rm=0, shift_imm=0, shift=0, carry_in=0, rf_rd_en=0, rf_addr=0; instr_ready=1 once in IDLE.
REQ-026 Reset mid-operation SHALL abandon the instruction with no partial output.

Configuration
REQ-027 Macro SHIFTER_OPSEQ_REGSHIFT_EN: defined -> REQ-019..021 implemented, illegal constant 0.
REQ-028 Not defined -> register-shift instructions go IDLE->OUT with illegal=1, op_valid 1 cycle after accept, no RF read, bypass_en=0; other forms unchanged.

Verification
REQ-029 I=1, rot=1, imm8=0x0A, cflag=1 -> next cycle op_valid=1, Rm=0x0000000A, shift=11, shift_imm=2, carry_in=1.
REQ-030 I=1, rot=0, imm8=0xFF -> Rm=0x000000FF, shift=00, shift_imm=0, no rf_rd_en pulse.
REQ-031 Imm-shift LSR #4, Rm=r2=0x000000F0 -> rf_addr=2 one cycle, op_valid 2 cycles after accept, Rm=0xF0, shift=01, shift_imm=4.
REQ-032 Reg-shift LSL, r3=32, r1=0x00000001 -> op_valid 3 cycles after accept, bypass_en=1, bypass_val=0, bypass_c=1; repeat r3=0 -> shift=00, shift_imm=0, bypass_en=0.
REQ-033 op_ready=0 for 5 cycles in OUT -> outputs unchanged, instr_ready=0; op_ready=1 -> IDLE and instr_ready=1 next cycle.
REQ-034 reset_n low during RD_RS -> op_valid=0 and state IDLE immediately; after release, new instruction processed normally.

Source files
------------

// File: rtl/shifter_operand_seq.sv
// Sequences a data-processing instruction's shifter operand: decodes the form,
// reads Rs/Rm from the register file, and presents operands to shifter_32.
// Optional register-shift support is enabled by defining SHIFTER_OPSEQ_REGSHIFT_EN.
module shifter_operand_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rf_addr,
  output logic        rf_rd_en,
  input  logic [31:0] rf_data,
  input  logic        cflag,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] Rm,
  output logic [4:0]  shift_imm,
  output logic [1:0]  shift,
  output logic        carry_in,
  output logic        shift_en,
  output logic        bypass_en,
  output logic [31:0] bypass_val,
  output logic        bypass_c,
  output logic        illegal
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_RS = 2'd1,
    S_RD_RM = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t          r_state,      w_state_nxt;
  logic [6:0]      r_sfield,     w_sfield_nxt;     // instr[11:5]
  logic [AW-1:0]   r_rm_addr,    w_rm_addr_nxt;
  logic            r_op_valid,   w_op_valid_nxt;
  logic [DW-1:0]   r_rm,         w_rm_nxt;
  logic [4:0]      r_shift_imm,  w_shift_imm_nxt;
  logic [1:0]      r_shift,      w_shift_nxt;
  logic            r_carry_in,   w_carry_in_nxt;
  logic            r_bypass_en,  w_bypass_en_nxt;
  logic [DW-1:0]   r_bypass_val, w_bypass_val_nxt;
  logic            r_bypass_c,   w_bypass_c_nxt;
  logic            r_illegal,    w_illegal_nxt;
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
  logic            r_regshift,   w_regshift_nxt;
  logic [7:0]      r_amt,        w_amt_nxt;
  logic            w_amt_hi;
  logic            w_amt_eq32;
  assign w_amt_hi   = |r_amt[7:5];
  assign w_amt_eq32 = (r_amt == 8'd32);
`endif

  logic w_unused_instr;
  assign w_unused_instr = ^{instr[31:26], instr[24:12]};

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_sfield_nxt     = r_sfield;
    w_rm_addr_nxt    = r_rm_addr;
    w_op_valid_nxt   = r_op_valid;
    w_rm_nxt         = r_rm;
    w_shift_imm_nxt  = r_shift_imm;
    w_shift_nxt      = r_shift;
    w_carry_in_nxt   = r_carry_in;
    w_bypass_en_nxt  = r_bypass_en;
    w_bypass_val_nxt = r_bypass_val;
    w_bypass_c_nxt   = r_bypass_c;
    w_illegal_nxt    = r_illegal;
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
    w_regshift_nxt   = r_regshift;
    w_amt_nxt        = r_amt;
`endif
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_sfield_nxt     = instr[11:5];
          w_rm_addr_nxt    = instr[3:0];
          w_carry_in_nxt   = cflag;
          w_illegal_nxt    = 1'b0;
          w_bypass_en_nxt  = 1'b0;
          w_bypass_val_nxt = '0;
          w_bypass_c_nxt   = 1'b0;
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
          w_regshift_nxt   = instr[4];
`endif
          if (instr[25]) begin
            w_state_nxt    = S_OUT;
            w_op_valid_nxt = 1'b1;
            w_rm_nxt       = DW'({24'b0, instr[7:0]});
            if (instr[11:8] != 4'd0) begin
              w_shift_nxt     = 2'b11;
              w_shift_imm_nxt = {instr[11:8], 1'b0};
            end else begin
              w_shift_nxt     = 2'b00;
              w_shift_imm_nxt = 5'd0;
            end
          end else if (!instr[4]) begin
            w_state_nxt = S_RD_RM;
          end else begin
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
            w_state_nxt = S_RD_RS;
`else
            w_state_nxt     = S_OUT;
            w_op_valid_nxt  = 1'b1;
            w_illegal_nxt   = 1'b1;
            w_rm_nxt        = '0;
            w_shift_nxt     = 2'b00;
            w_shift_imm_nxt = 5'd0;
`endif
          end
        end
      end
      S_RD_RS: begin
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
        w_amt_nxt = rf_data[7:0];
`endif
        w_state_nxt = S_RD_RM;
      end
      S_RD_RM: begin
        w_state_nxt     = S_OUT;
        w_op_valid_nxt  = 1'b1;
        w_rm_nxt        = rf_data;
        w_shift_nxt     = r_sfield[1:0];
        w_shift_imm_nxt = r_sfield[6:2];
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
        // Amounts >= 32 are resolved here; ROR folds back to a 0..31 rotate
        if (r_regshift) begin
          w_shift_imm_nxt = r_amt[4:0];
          if (r_amt == 8'd0) begin
            w_shift_nxt = 2'b00;
          end else if (w_amt_hi) begin
            case (r_sfield[1:0])
              2'b00: begin
                w_bypass_en_nxt  = 1'b1;
                w_bypass_val_nxt = '0;
                w_bypass_c_nxt   = w_amt_eq32 & rf_data[0];
              end
              2'b01: begin
                w_bypass_en_nxt  = 1'b1;
                w_bypass_val_nxt = '0;
                w_bypass_c_nxt   = w_amt_eq32 & rf_data[31];
              end
              2'b10: begin
                w_bypass_en_nxt  = 1'b1;
                w_bypass_val_nxt = {DW{rf_data[31]}};
                w_bypass_c_nxt   = rf_data[31];
              end
              default: begin
                if (r_amt[4:0] == 5'd0) begin
                  w_bypass_en_nxt  = 1'b1;
                  w_bypass_val_nxt = rf_data;
                  w_bypass_c_nxt   = rf_data[31];
                end
              end
            endcase
          end
        end
`endif
      end
      S_OUT: begin
        if (op_ready) begin
          w_state_nxt     = S_IDLE;
          w_op_valid_nxt  = 1'b0;
          w_illegal_nxt   = 1'b0;
          w_bypass_en_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sfield     <= '0;
      r_rm_addr    <= '0;
      r_op_valid   <= 1'b0;
      r_rm         <= '0;
      r_shift_imm  <= '0;
      r_shift      <= '0;
      r_carry_in   <= 1'b0;
      r_bypass_en  <= 1'b0;
      r_bypass_val <= '0;
      r_bypass_c   <= 1'b0;
      r_illegal    <= 1'b0;
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
      r_regshift   <= 1'b0;
      r_amt        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_sfield     <= w_sfield_nxt;
      r_rm_addr    <= w_rm_addr_nxt;
      r_op_valid   <= w_op_valid_nxt;
      r_rm         <= w_rm_nxt;
      r_shift_imm  <= w_shift_imm_nxt;
      r_shift      <= w_shift_nxt;
      r_carry_in   <= w_carry_in_nxt;
      r_bypass_en  <= w_bypass_en_nxt;
      r_bypass_val <= w_bypass_val_nxt;
      r_bypass_c   <= w_bypass_c_nxt;
      r_illegal    <= w_illegal_nxt;
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
      r_regshift   <= w_regshift_nxt;
      r_amt        <= w_amt_nxt;
`endif
    end
  end

  // Handshake and register-file port are decoded straight from state
  always_comb begin
    instr_ready = (r_state == S_IDLE);
    rf_rd_en    = (r_state == S_RD_RS) || (r_state == S_RD_RM);
    case (r_state)
      S_RD_RS: rf_addr = r_sfield[6:3];
      S_RD_RM: rf_addr = r_rm_addr;
      default: rf_addr = '0;
    endcase
  end

  assign op_valid   = r_op_valid;
  assign shift_en   = r_op_valid;
  assign Rm         = r_rm;
  assign shift_imm  = r_shift_imm;
  assign shift      = r_shift;
  assign carry_in   = r_carry_in;
  assign bypass_en  = r_bypass_en;
  assign bypass_val = r_bypass_val;
  assign bypass_c   = r_bypass_c;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_shifter_operand_seq.sv
// Randomized bench for shifter_operand_seq against a transaction-level model
// of operand decode, register reads and >=32 shift-amount resolution.
module tb_shifter_operand_seq;

  logic        clk, reset_n, instr_valid, instr_ready, rf_rd_en, cflag;
  logic [31:0] instr, rf_data, Rm, bypass_val;
  logic [3:0]  rf_addr;
  logic        op_valid, op_ready, carry_in, shift_en, bypass_en, bypass_c, illegal;
  logic [4:0]  shift_imm;
  logic [1:0]  shift;

  logic [31:0] regs [16];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          lat;
    int          nrd;
    logic [3:0]  a0, a1;
    logic [31:0] rm;
    logic [1:0]  sh;
    logic [4:0]  si;
    logic        c, byp, bc, ill;
    logic [31:0] bv;
  } exp_t;

  shifter_operand_seq dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_addr(rf_addr), .rf_rd_en(rf_rd_en),
    .rf_data(rf_data), .cflag(cflag), .op_valid(op_valid), .op_ready(op_ready),
    .Rm(Rm), .shift_imm(shift_imm), .shift(shift), .carry_in(carry_in),
    .shift_en(shift_en), .bypass_en(bypass_en), .bypass_val(bypass_val),
    .bypass_c(bypass_c), .illegal(illegal)
  );

  assign rf_data = regs[rf_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic cf);
    exp_t e;
    int rot, amt;
    logic [31:0] rmv;
    e.lat = 1; e.nrd = 0; e.a0 = 4'd0; e.a1 = 4'd0;
    e.rm = 32'd0; e.sh = 2'd0; e.si = 5'd0;
    e.c = cf; e.byp = 1'b0; e.bc = 1'b0; e.ill = 1'b0; e.bv = 32'd0;
    if (ins[25]) begin
      rot  = int'(ins[11:8]);
      e.rm = ins & 32'h0000_00FF;
      if (rot != 0) begin
        e.sh = 2'd3;
        e.si = 5'(rot * 2);
      end
    end else if (!ins[4]) begin
      e.lat = 2; e.nrd = 1; e.a0 = ins[3:0];
      e.rm  = regs[ins[3:0]];
      e.sh  = ins[6:5];
      e.si  = ins[11:7];
    end else begin
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
      e.lat = 3; e.nrd = 2; e.a0 = ins[11:8]; e.a1 = ins[3:0];
      amt  = int'(regs[ins[11:8]] % 256);
      rmv  = regs[ins[3:0]];
      e.rm = rmv;
      e.sh = ins[6:5];
      if (amt == 0) begin
        e.sh = 2'd0;
        e.si = 5'd0;
      end else if (amt < 32) begin
        e.si = 5'(amt);
      end else begin
        case (int'(ins[6:5]))
          0: begin e.byp = 1'b1; e.bv = 32'd0; e.bc = (amt == 32) ? rmv[0] : 1'b0; end
          1: begin e.byp = 1'b1; e.bv = 32'd0; e.bc = (amt == 32) ? rmv[31] : 1'b0; end
          2: begin e.byp = 1'b1; e.bv = rmv[31] ? 32'hFFFF_FFFF : 32'd0; e.bc = rmv[31]; end
          default: begin
            if (amt % 32 == 0) begin
              e.byp = 1'b1; e.bv = rmv; e.bc = rmv[31];
            end else begin
              e.sh = 2'd3;
              e.si = 5'(amt % 32);
            end
          end
        endcase
      end
`else
      e.ill = 1'b1;
`endif
    end
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    check("op_valid", 32'(op_valid), 32'd1);
    check("shift_en", 32'(shift_en), 32'd1);
    check("ready_busy", 32'(instr_ready), 32'd0);
    check("rd_en_out", 32'(rf_rd_en), 32'd0);
    check("carry_in", 32'(carry_in), 32'(e.c));
    check("illegal", 32'(illegal), 32'(e.ill));
    check("bypass_en", 32'(bypass_en), 32'(e.byp));
    if (!e.ill) check("Rm", Rm, e.rm);
    if (e.byp) begin
      check("bypass_val", bypass_val, e.bv);
      check("bypass_c", 32'(bypass_c), 32'(e.bc));
    end else if (!e.ill) begin
      check("shift", 32'(shift), 32'(e.sh));
      check("shift_imm", 32'(shift_imm), 32'(e.si));
    end
  endtask

  task automatic run_txn(input logic [31:0] ins, input logic cf, input int hold);
    exp_t e;
    logic [3:0] rd_q[$];
    int cyc;
    logic seq_ok;
    e = model(ins, cf);
    @(negedge clk);
    check("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr = ins; cflag = cf; op_ready = 1'b0;
    @(posedge clk); #1;
    // Junk offered while busy must be ignored
    instr = $urandom; cflag = 1'($urandom);
    cyc = 1; seq_ok = 1'b1;
    while (!op_valid && cyc < 8) begin
      if (rf_rd_en) rd_q.push_back(rf_addr);
      else if (rf_addr != 4'd0) seq_ok = 1'b0;
      if (instr_ready) seq_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    instr_valid = 1'b0;
    check("latency", 32'(cyc), 32'(e.lat));
    check("rd_count", 32'(rd_q.size()), 32'(e.nrd));
    if (rd_q.size() > 0 && e.nrd > 0) check("rd_addr0", 32'(rd_q[0]), 32'(e.a0));
    if (rd_q.size() > 1 && e.nrd > 1) check("rd_addr1", 32'(rd_q[1]), 32'(e.a1));
    check("busy_seq", 32'(seq_ok), 32'd1);
    check_out(e);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_out(e);
    end
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
    check("op_valid_done", 32'(op_valid), 32'd0);
    check("ready_done", 32'(instr_ready), 32'd1);
  endtask

  task automatic rand_regs(input logic [3:0] rs);
    int k;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    k = $urandom_range(0, 5);
    case (k)
      0: regs[rs][7:0] = 8'd0;
      1: regs[rs][7:0] = 8'($urandom_range(1, 31));
      2: regs[rs][7:0] = 8'd32;
      3: regs[rs][7:0] = 8'($urandom_range(33, 255));
      4: regs[rs][7:0] = 8'($urandom_range(0, 3) * 32);
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] ins;
    logic [3:0]  mid_addr;
    clk = 1'b0; reset_n = 1'b0; instr_valid = 1'b0; instr = '0;
    cflag = 1'b0; op_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    #2;
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_bypass_en", 32'(bypass_en), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_Rm", Rm, 32'd0);
    check("rst_shift_imm", 32'(shift_imm), 32'd0);
    check("rst_shift", 32'(shift), 32'd0);
    check("rst_carry_in", 32'(carry_in), 32'd0);
    check("rst_rd_en", 32'(rf_rd_en), 32'd0);
    check("rst_rf_addr", 32'(rf_addr), 32'd0);
    check("rst_ready", 32'(instr_ready), 32'd1);
    @(negedge clk); reset_n = 1'b1;

    // Directed: immediate forms, imm-shift LSR #4, register LSL by 32 and 0, long stall
    run_txn(32'h0200_010A, 1'b1, 0);
    run_txn(32'h0200_00FF, 1'b0, 1);
    regs[2] = 32'h0000_00F0;
    run_txn(32'h0000_0222, 1'b0, 0);
    regs[3] = 32'd32; regs[1] = 32'd1;
    run_txn(32'h0000_0311, 1'b0, 0);
    regs[3] = 32'd0;
    run_txn(32'h0000_0311, 1'b1, 0);
    run_txn(32'h0200_0A55, 1'b1, 5);

    // Reset in the middle of a register read abandons the instruction
`ifdef SHIFTER_OPSEQ_REGSHIFT_EN
    ins = 32'h0000_0311; mid_addr = 4'd3;
`else
    ins = 32'h0000_0222; mid_addr = 4'd2;
`endif
    @(negedge clk);
    instr_valid = 1'b1; instr = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("mid_rd_en", 32'(rf_rd_en), 32'd1);
    check("mid_rd_addr", 32'(rf_addr), 32'(mid_addr));
    reset_n = 1'b0;
    #1;
    check("mid_rst_op_valid", 32'(op_valid), 32'd0);
    check("mid_rst_ready", 32'(instr_ready), 32'd1);
    check("mid_rst_rd_en", 32'(rf_rd_en), 32'd0);
    check("mid_rst_rf_addr", 32'(rf_addr), 32'd0);
    check("mid_rst_Rm", Rm, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_op_valid", 32'(op_valid), 32'd0);
    regs[3] = 32'd33; regs[1] = 32'h8000_0001;
    run_txn(32'h0000_0311, 1'b1, 0);

    for (int t = 0; t < 300; t++) begin
      ins = $urandom;
      rand_regs(ins[11:8]);
      run_txn(ins, 1'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
